// File: rtl/alu_op_sequencer.sv
// Sequences load-A / load-B / execute on the 8-bit ALU port and returns the result.
// Define ALU_SEQ_CHECK_EN to build the internal reference model and rsp_mismatch.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_fsel,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       alu_ui_in,
  output logic [7:0]       alu_ctrl,
  input  logic [7:0]       alu_res_lo,
  input  logic [7:0]       alu_res_hi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [13:0]      rsp_result,
  output logic             rsp_flag,
  output logic             rsp_ovf,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOADA = 2'd1;
  localparam logic [1:0] S_LOADB = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;
  localparam logic [1:0] S_RESP_UNUSED = 2'd0;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             resp_q, resp_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       fsel_q, fsel_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [13:0]      res_q, res_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             accept, capture, rsp_hs;
  logic             mis_now;

  // RESP is tracked by its own bit so the four load/exec states fit 2 bits
  assign cmd_ready = (state_q == S_IDLE) & ~resp_q & ~rst_n;
  assign accept    = cmd_valid & cmd_ready;
  assign capture   = (state_q == S_EXEC) & ~resp_q & (cnt_q == 4'd0);
  assign rsp_hs    = resp_q & rsp_ready;

  assign rsp_valid    = resp_q;
  assign rsp_result   = res_q;
  assign rsp_flag     = flag_q;
  assign rsp_ovf      = ovf_q;
  assign rsp_mismatch = mis_q;
  assign ops_done     = ops_q;

  always_comb begin
    alu_ui_in = b_q;
    alu_ctrl  = {2'b00, fsel_q, 1'b0, op_q};
    if (!resp_q && state_q == S_LOADA) begin
      alu_ui_in = a_q;
      alu_ctrl  = {2'b00, fsel_q, 1'b1, op_q};
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [13:0] exp_res;
  logic        exp_flag;
  logic [15:0] prod;

  assign prod = {8'h00, a_q} * {8'h00, b_q};

  always_comb begin
    exp_res = 14'd0;
    unique case (op_q)
      3'b000: exp_res = {6'd0, a_q} + {6'd0, b_q};
      3'b001: exp_res = {6'd0, a_q} - {6'd0, b_q};
      3'b010: exp_res = {7'd0, a_q[7:1]};
      3'b011: exp_res = {6'd0, a_q[6:0], 1'b0};
      3'b100: exp_res = {6'd0, a_q & b_q};
      3'b101: exp_res = {6'd0, a_q | b_q};
      3'b110: exp_res = {6'd0, a_q ^ b_q};
      3'b111: exp_res = prod[13:0];
    endcase
  end

  always_comb begin
    exp_flag = 1'b0;
    unique case (fsel_q)
      2'b00: exp_flag = a_q > b_q;
      2'b01: exp_flag = a_q == b_q;
      2'b10: exp_flag = a_q == 8'd0;
      2'b11: exp_flag = ~a_q[0];
    endcase
  end

  assign mis_now = ({alu_res_hi[5:0], alu_res_lo} != exp_res)
                 | (alu_res_hi[6] != exp_flag)
                 | (alu_res_hi[7] != (exp_res[13:8] != 6'd0));
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fsel_d  = fsel_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    mis_d   = mis_q;
    ops_d   = ops_q;
    if (resp_q) begin
      if (rsp_hs) begin
        resp_d  = 1'b0;
        state_d = S_IDLE;
        ops_d   = ops_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d    = cmd_op;
            fsel_d  = cmd_fsel;
            a_d     = cmd_a;
            b_d     = cmd_b;
            state_d = S_LOADA;
          end
        end
        S_LOADA: state_d = S_LOADB;
        S_LOADB: begin
          cnt_d   = SETTLE_M1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (capture) begin
            res_d   = {alu_res_hi[5:0], alu_res_lo};
            flag_d  = alu_res_hi[6];
            ovf_d   = alu_res_hi[7];
            mis_d   = mis_now;
            resp_d  = 1'b1;
            state_d = S_RESP_UNUSED;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      resp_q  <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      fsel_q  <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      res_q   <= 14'd0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fsel_q  <= fsel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      mis_q   <= mis_d;
      ops_q   <= ops_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU core, directed commands, queue scoreboard.
module tb_alu_op_sequencer;
  localparam int S = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [1:0]  cmd_fsel = 2'd0;
  logic [7:0]  cmd_a = 8'd0;
  logic [7:0]  cmd_b = 8'd0;
  logic [7:0]  alu_ui_in;
  logic [7:0]  alu_ctrl;
  logic [7:0]  alu_res_lo;
  logic [7:0]  alu_res_hi;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [13:0] rsp_result;
  logic        rsp_flag;
  logic        rsp_ovf;
  logic        rsp_mismatch;
  logic [7:0]  ops_done;

  int tests = 0;
  int fails = 0;
  logic flip_lo = 1'b0;
  logic [16:0] expq[$];

  alu_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fsel(cmd_fsel),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ui_in(alu_ui_in), .alu_ctrl(alu_ctrl),
    .alu_res_lo(alu_res_lo), .alu_res_hi(alu_res_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .rsp_ovf(rsp_ovf), .rsp_mismatch(rsp_mismatch),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // behavioural ALU core: A loads when enA=1, otherwise B loads
  logic [7:0]  ra = 8'd0;
  logic [7:0]  rb = 8'd0;
  logic [13:0] mres;
  logic        mflag;
  logic [15:0] mprod;
  always @(posedge clk) begin
    if (alu_ctrl[3]) ra <= alu_ui_in;
    else rb <= alu_ui_in;
  end
  assign mprod = {8'h00, ra} * {8'h00, rb};
  always_comb begin
    mres = 14'd0;
    case (alu_ctrl[2:0])
      3'b000: mres = {6'd0, ra} + {6'd0, rb};
      3'b001: mres = {6'd0, ra} - {6'd0, rb};
      3'b010: mres = {7'd0, ra[7:1]};
      3'b011: mres = {6'd0, ra[6:0], 1'b0};
      3'b100: mres = {6'd0, ra & rb};
      3'b101: mres = {6'd0, ra | rb};
      3'b110: mres = {6'd0, ra ^ rb};
      default: mres = mprod[13:0];
    endcase
    mflag = 1'b0;
    case (alu_ctrl[5:4])
      2'b00: mflag = ra > rb;
      2'b01: mflag = ra == rb;
      2'b10: mflag = ra == 8'd0;
      default: mflag = ~ra[0];
    endcase
  end
  assign alu_res_lo = mres[7:0] ^ {7'd0, flip_lo};
  assign alu_res_hi = {mres[13:8] != 6'd0, mflag, mres[13:8]};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic        pv = 1'b0;
    logic        phs = 1'b0;
    logic [16:0] pval = '0;
    logic [16:0] cur;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      cur = {rsp_result, rsp_flag, rsp_ovf, rsp_mismatch};
      if (rst_n) begin
        pv = 1'b0;
        phs = 1'b0;
      end else begin
        if (pv && !phs) begin
          chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
          chk("rsp_hold_stable", {15'd0, cur}, {15'd0, pval});
        end
        if (rsp_valid && rsp_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk("rsp_result", {18'd0, rsp_result}, {18'd0, e[16:3]});
            chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, e[2]});
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e[1]});
            chk("rsp_mismatch", {31'd0, rsp_mismatch}, {31'd0, e[0]});
          end
        end
        pv = rsp_valid;
        phs = rsp_valid && rsp_ready;
        pval = cur;
      end
    end
  endtask

  task automatic accept_cmd(input logic [2:0] op, input logic [1:0] fs,
                            input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op;
    cmd_fsel = fs;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] fs,
                      input logic [7:0] a, input logic [7:0] b,
                      input int hold, input logic [13:0] er,
                      input logic ef, input logic eo, input logic em,
                      input logic [7:0] eops);
    int lat = 0;
    expq.push_back({er, ef, eo, em});
    if (hold > 0) rsp_ready = 1'b0;
    accept_cmd(op, fs, a, b);
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    chk("rsp_latency", lat, 2 + S);
    chk("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("held_valid", {31'd0, rsp_valid}, 32'd1);
      chk("held_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    chk("ops_done", {24'd0, ops_done}, {24'd0, eops});
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_ctrl", {24'd0, alu_ctrl}, 32'd0);
    chk("idle_ui", {24'd0, alu_ui_in}, 32'd0);
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ops", {24'd0, ops_done}, 32'd0);

    send(3'b000, 2'b00, 8'd200, 8'd100, 0, 14'h012C, 1'b1, 1'b1, 1'b0, 8'd1);
    send(3'b001, 2'b01, 8'd3, 8'd5, 0, 14'h3FFE, 1'b0, 1'b1, 1'b0, 8'd2);
    send(3'b100, 2'b10, 8'hF0, 8'h3C, 0, 14'h0030, 1'b0, 1'b0, 1'b0, 8'd3);
    #1;
    chk("idle_ctrl_keep", {24'd0, alu_ctrl}, 32'h24);
    chk("idle_ui_lastb", {24'd0, alu_ui_in}, 32'h3C);
    send(3'b111, 2'b11, 8'd255, 8'd255, 6, 14'h3E01, 1'b0, 1'b1, 1'b0, 8'd4);

    // reset lands while the shl command is in LOAD_B
    accept_cmd(3'b011, 2'b11, 8'h81, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_ui", {24'd0, alu_ui_in}, 32'd0);
    chk("mid_rst_ctrl", {24'd0, alu_ctrl}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_result", {18'd0, rsp_result}, 32'd0);
    chk("mid_rst_ops", {24'd0, ops_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);

    send(3'b011, 2'b11, 8'h81, 8'h00, 0, 14'h0002, 1'b0, 1'b0, 1'b0, 8'd1);
    send(3'b110, 2'b01, 8'h55, 8'hFF, 0, 14'h00AA, 1'b0, 1'b0, 1'b0, 8'd2);
    send(3'b010, 2'b10, 8'h80, 8'h07, 0, 14'h0040, 1'b0, 1'b0, 1'b0, 8'd3);
`ifdef ALU_SEQ_CHECK_EN
    flip_lo = 1'b1;
    send(3'b101, 2'b00, 8'd1, 8'd2, 0, 14'h0002, 1'b0, 1'b0, 1'b1, 8'd4);
    flip_lo = 1'b0;
    send(3'b101, 2'b00, 8'd1, 8'd2, 0, 14'h0003, 1'b0, 1'b0, 1'b0, 8'd5);
`else
    send(3'b101, 2'b00, 8'd1, 8'd2, 0, 14'h0003, 1'b0, 1'b0, 1'b0, 8'd4);
`endif
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
